// File: rtl/lock_keypad_seq_pkg.sv
// Shared types and defaults for the keypad sequencer and the lock FSM it feeds.
package lock_pkg;

  localparam int DEF_DIGITS = 4;
  localparam int DEF_DIGIT_W = 4;
  localparam int DEF_TIMEOUT = 1000000;
  localparam logic [15:0] DEF_INIT_CODE = 16'h1234;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    EVAL
  } seq_state_e;

  // Status encodings the lock FSM reports; kept here so both blocks agree.
  typedef enum logic [1:0] {
    LOCK_LOCKED,
    LOCK_OPEN,
    LOCK_LOAD,
    LOCK_ALARM
  } lock_status_e;

endpackage

// File: rtl/lock_keypad_seq_if.sv
// Keypad-side and lock-FSM-side signals of the entry sequencer.
interface lock_keypad_seq_if
  import lock_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W
);
  localparam int CW = $clog2(DIGITS + 1);

  logic               key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic               key_enter;
  logic               key_change;
  logic               load_strobe;
  logic               alarm;
  logic               compare;
  logic               enter;
  logic               change;
  logic [CW-1:0]      entry_count;
  logic               busy;

  modport master (
    output key_valid, key_digit, key_enter, key_change, load_strobe, alarm,
    input  compare, enter, change, entry_count, busy
  );

  modport slave (
    input  key_valid, key_digit, key_enter, key_change, load_strobe, alarm,
    output compare, enter, change, entry_count, busy
  );

endinterface

// File: rtl/lock_keypad_seq_digit_shift_reg.sv
// Entry register: newest digit enters at the LSB end, full entries ignore further digits.
module digit_shift_reg
  import lock_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        shift,
  input  logic                        clear,
  input  logic [DIGIT_W-1:0]          digit,
  output logic [DIGITS*DIGIT_W-1:0]   data,
  output logic [$clog2(DIGITS+1)-1:0] count
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int W = DIGITS * DIGIT_W;

  // Clear takes priority so an evaluation or discard never keeps a late digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data  <= '0;
      count <= '0;
    end else if (clear) begin
      data  <= '0;
      count <= '0;
    end else if (shift && (count < CW'(DIGITS))) begin
      data  <= {data[W-DIGIT_W-1:0], digit};
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lock_keypad_seq.sv
// Keypad entry sequencer: collects digits, holds the unlock code and pulses the lock FSM.
module lock_keypad_seq
  import lock_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter logic [DIGITS*DIGIT_W-1:0] INIT_CODE = DEF_INIT_CODE
) (
  input logic              clock,
  input logic              reset,
  lock_keypad_seq_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int W = DIGITS * DIGIT_W;
  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_e    state;
  logic [TW-1:0] timer;
  logic          latchedChange;
  logic [W-1:0]  entry;
  logic [W-1:0]  lastEntry;
  logic [W-1:0]  storedCode;
  logic [CW-1:0] count;
  logic          compareQ, enterQ, changeQ, busyQ;
  logic          oneButton, anyButton, timerExpired, shiftEn, clearEn;

  always_comb begin
    oneButton    = bus.key_enter ^ bus.key_change;
    anyButton    = bus.key_enter | bus.key_change;
    timerExpired = (timer == TW'(TIMEOUT - 1));
    shiftEn      = !bus.alarm && bus.key_valid && !anyButton && (state != EVAL);
    clearEn      = bus.alarm || (state == EVAL) ||
                   ((state == COLLECT) && !oneButton && !bus.key_valid && timerExpired);
  end

  digit_shift_reg #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W)
  ) shiftReg (
    .clock(clock),
    .reset(reset),
    .shift(shiftEn),
    .clear(clearEn),
    .digit(bus.key_digit),
    .data (entry),
    .count(count)
  );

  // Pulses default low so every assertion lasts exactly one cycle; alarm overrides the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      latchedChange <= 1'b0;
      compareQ      <= 1'b0;
      enterQ        <= 1'b0;
      changeQ       <= 1'b0;
      busyQ         <= 1'b0;
      lastEntry     <= '0;
      storedCode    <= INIT_CODE;
    end else begin
      compareQ <= 1'b0;
      enterQ   <= 1'b0;
      changeQ  <= 1'b0;
      if (bus.load_strobe) storedCode <= lastEntry;
      if (bus.alarm) begin
        state <= IDLE;
        busyQ <= 1'b0;
        timer <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (oneButton) begin
              latchedChange <= bus.key_change;
              state         <= EVAL;
              busyQ         <= 1'b1;
            end else if (bus.key_valid && !anyButton) begin
              state <= COLLECT;
              busyQ <= 1'b1;
              timer <= '0;
            end
          end
          COLLECT: begin
            if (oneButton) begin
              latchedChange <= bus.key_change;
              state         <= EVAL;
              timer         <= '0;
            end else if (bus.key_valid) begin
              timer <= '0;
            end else if (timerExpired) begin
              state <= IDLE;
              busyQ <= 1'b0;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          EVAL: begin
            compareQ  <= (count == CW'(DIGITS)) && (entry == storedCode);
            enterQ    <= !latchedChange;
            changeQ   <= latchedChange;
            lastEntry <= entry;
            state     <= IDLE;
            busyQ     <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busyQ <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.compare     = compareQ;
  assign bus.enter       = enterQ;
  assign bus.change      = changeQ;
  assign bus.busy        = busyQ;
  assign bus.entry_count = count;

endmodule

// File: tb/tb_lock_keypad_seq.sv
// Directed bench for the keypad sequencer with a short timeout.
module tb_lock_keypad_seq;

  logic clock;
  logic reset;
  int   testsRun;
  int   failCount;

  lock_keypad_seq_if #(.DIGITS(4), .DIGIT_W(4)) bus ();

  lock_keypad_seq #(
    .DIGITS   (4),
    .DIGIT_W  (4),
    .TIMEOUT  (8),
    .INIT_CODE(16'h1234)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of keypad inputs starting at a falling edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] digit, input logic enterBtn, input logic changeBtn);
    bus.key_valid  = valid;
    bus.key_digit  = digit;
    bus.key_enter  = enterBtn;
    bus.key_change = changeBtn;
    @(negedge clock);
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'h0;
    bus.key_enter  = 1'b0;
    bus.key_change = 1'b0;
  endtask

  task automatic keyDigits(input logic [31:0] seq, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, seq[4*(n-1-i) +: 4], 1'b0, 1'b0);
  endtask

  task automatic observePulse(input string tag, input logic expEnter, input logic expChange, input logic expCompare);
    @(negedge clock);
    checkOutput({tag, ".enter"}, 32'(bus.enter), 32'(expEnter));
    checkOutput({tag, ".change"}, 32'(bus.change), 32'(expChange));
    checkOutput({tag, ".compare"}, 32'(bus.compare), 32'(expCompare));
    @(negedge clock);
    checkOutput({tag, ".pulseEnd"}, {30'd0, bus.enter, bus.change}, 32'd0);
    checkOutput({tag, ".count"}, 32'(bus.entry_count), 32'd0);
    checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    testsRun        = 0;
    failCount       = 0;
    bus.key_valid   = 1'b0;
    bus.key_digit   = 4'h0;
    bus.key_enter   = 1'b0;
    bus.key_change  = 1'b0;
    bus.load_strobe = 1'b0;
    bus.alarm       = 1'b0;
    doReset();
    checkOutput("reset.pulses", {29'd0, bus.enter, bus.change, bus.compare}, 32'd0);
    checkOutput("reset.count", 32'(bus.entry_count), 32'd0);
    checkOutput("reset.busy", 32'(bus.busy), 32'd0);

    keyDigits(32'h1234, 4);
    checkOutput("match.count", 32'(bus.entry_count), 32'd4);
    checkOutput("match.busy", 32'(bus.busy), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("match", 1'b1, 1'b0, 1'b1);

    keyDigits(32'h123, 3);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("short", 1'b1, 1'b0, 1'b0);

    keyDigits(32'h12349, 5);
    checkOutput("extra.count", 32'(bus.entry_count), 32'd4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("extra", 1'b1, 1'b0, 1'b1);

    // Digit arriving with a button is dropped, leaving only three digits.
    keyDigits(32'h123, 3);
    applyStimulus(1'b1, 4'h4, 1'b1, 1'b0);
    observePulse("btnWins", 1'b1, 1'b0, 1'b0);

    keyDigits(32'h1234, 4);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    observePulse("chg", 1'b0, 1'b1, 1'b1);
    keyDigits(32'h5678, 4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("newCode", 1'b1, 1'b0, 1'b0);
    bus.load_strobe = 1'b1;
    @(negedge clock);
    bus.load_strobe = 1'b0;
    keyDigits(32'h5678, 4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("loaded", 1'b1, 1'b0, 1'b1);
    keyDigits(32'h1234, 4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("oldCode", 1'b1, 1'b0, 1'b0);

    // Back-to-back: second button the cycle after EVAL.
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("b2b.enter", 32'(bus.enter), 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    observePulse("b2b", 1'b0, 1'b1, 1'b0);

    doReset();
    keyDigits(32'h1, 1);
    repeat (7) @(negedge clock);
    checkOutput("timeout.before", 32'(bus.entry_count), 32'd1);
    checkOutput("timeout.busyBefore", 32'(bus.busy), 32'd1);
    @(negedge clock);
    checkOutput("timeout.count", 32'(bus.entry_count), 32'd0);
    checkOutput("timeout.busy", 32'(bus.busy), 32'd0);
    checkOutput("timeout.noPulse", {29'd0, bus.enter, bus.change, bus.compare}, 32'd0);
    keyDigits(32'h1234, 4);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("afterTimeout", 1'b1, 1'b0, 1'b1);

    bus.alarm = 1'b1;
    keyDigits(32'h1234, 4);
    checkOutput("alarm.count", 32'(bus.entry_count), 32'd0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    observePulse("alarm", 1'b0, 1'b0, 1'b0);
    bus.alarm = 1'b0;

    applyStimulus(1'b0, 4'h0, 1'b1, 1'b1);
    checkOutput("both.busy", 32'(bus.busy), 32'd0);
    observePulse("both", 1'b0, 1'b0, 1'b0);

    keyDigits(32'h12, 2);
    checkOutput("midReset.before", 32'(bus.entry_count), 32'd2);
    #2 reset = 1'b1;
    #1;
    checkOutput("midReset.count", 32'(bus.entry_count), 32'd0);
    checkOutput("midReset.busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
